// File: rtl/shift_seq_if.sv
// Handshake/bus bundle for shift_seq: request fields in, registered result out.
// The carry signal exists only when SHIFT_SEQ_CARRY_EN is defined.
interface shift_seq_if;
  logic       start;
  logic [7:0] A;
  logic [1:0] opc;
  logic [2:0] amt;
  logic [7:0] out;
  logic       busy;
  logic       done;
`ifdef SHIFT_SEQ_CARRY_EN
  logic       carry;
`endif

`ifdef SHIFT_SEQ_CARRY_EN
  modport master (output start, A, opc, amt, input out, busy, done, carry);
  modport slave  (input start, A, opc, amt, output out, busy, done, carry);
`else
  modport master (output start, A, opc, amt, input out, busy, done);
  modport slave  (input start, A, opc, amt, output out, busy, done);
`endif
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle 8-bit rotate/shift sequencer, one bit position per clock.
// Optional carry-out of the last shifted bit: define SHIFT_SEQ_CARRY_EN.
module shift_seq (
  input  logic         clk,
  input  logic         rst,
  shift_seq_if.slave   bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam logic [1:0] OP_ROTR = 2'b00, OP_SLA = 2'b01, OP_SRA = 2'b10, OP_SRL = 2'b11;

  state_t     state_q, state_d;
  logic [7:0] wr_q, wr_d;
  logic [1:0] op_q, op_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] out_q, out_d;
  logic [7:0] step_val;
  logic       step_c;

  // Single-bit step of the working register; step_c is the bit leaving it.
  always_comb begin
    step_val = wr_q;
    step_c   = wr_q[0];
    case (op_q)
      OP_ROTR: step_val = {wr_q[0], wr_q[7:1]};
      OP_SLA:  begin step_val = {wr_q[6:0], 1'b0}; step_c = wr_q[7]; end
      OP_SRA:  step_val = {wr_q[7], wr_q[7:1]};
      OP_SRL:  step_val = {1'b0, wr_q[7:1]};
      default: step_val = wr_q;
    endcase
  end

`ifdef SHIFT_SEQ_CARRY_EN
  logic carry_q, carry_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 8'h00;
      op_q    <= 2'b00;
      cnt_q   <= 3'd0;
      out_q   <= 8'h00;
`ifdef SHIFT_SEQ_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
`ifdef SHIFT_SEQ_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end

  // Result registers are loaded on the edge that enters DONE, so they are
  // already valid while done is high and hold until the next completion.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
`ifdef SHIFT_SEQ_CARRY_EN
    carry_d = carry_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        wr_d  = bus.A;
        op_d  = bus.opc;
        cnt_d = bus.amt;
        if (bus.amt == 3'd0) begin
          state_d = DONE;
          out_d   = bus.A;
`ifdef SHIFT_SEQ_CARRY_EN
          carry_d = 1'b0;
`endif
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        wr_d  = step_val;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = DONE;
          out_d   = step_val;
`ifdef SHIFT_SEQ_CARRY_EN
          carry_d = step_c;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.out  = out_q;
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
`ifdef SHIFT_SEQ_CARRY_EN
    bus.carry = carry_q;
`endif
  end

`ifndef SHIFT_SEQ_CARRY_EN
  logic unused_step_c;
  assign unused_step_c = step_c;
`endif
endmodule

// File: tb/tb_shift_seq.sv
// Directed-vector bench for shift_seq; carry checks compile in only with
// SHIFT_SEQ_CARRY_EN.
module tb_shift_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  shift_seq_if bus();
  shift_seq dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input logic [2:0] amt);
    return (amt == 3'd0) ? 1 : int'(amt) + 1;
  endfunction

  // One operation from IDLE; optionally pokes start with A=55 in cycles 2..5.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [1:0] opc,
                        input logic [2:0] amt, input logic [7:0] want_out,
                        input logic want_c, input bit poke);
    int lat, bcnt;
    logic [7:0] held;
    lat = 0; bcnt = 0;
    bus.start = 1'b1; bus.A = a; bus.opc = opc; bus.amt = amt;
    do begin
      tick();
      lat++;
      if (bus.busy) bcnt++;
      bus.start = poke && (lat >= 2) && (lat <= 5);
      if (poke) begin bus.A = 8'h55; bus.amt = 3'd1; bus.opc = 2'b00; end
    end while (!bus.done && lat < 20);
    bus.start = 1'b0;
    chk({tag, " latency"}, lat, lat_of(amt));
    chk({tag, " busy cycles"}, bcnt, lat_of(amt));
    chk({tag, " out"}, bus.out, want_out);
`ifdef SHIFT_SEQ_CARRY_EN
    chk({tag, " carry"}, bus.carry, want_c);
`else
    if (want_c === 1'bx) $display("note: carry expectation undefined for %s", tag);
`endif
    held = bus.out;
    tick();
    chk({tag, " done drops"}, bus.done, 1'b0);
    chk({tag, " idle busy"}, bus.busy, 1'b0);
    chk({tag, " out held"}, bus.out, held);
  endtask

  logic [7:0] bb_a   [4] = '{8'h12, 8'h34, 8'hF1, 8'hA5};
  logic [1:0] bb_op  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [2:0] bb_amt [4] = '{3'd2, 3'd1, 3'd0, 3'd3};
  logic [7:0] bb_out [4] = '{8'h84, 8'h68, 8'hF1, 8'h14};
  logic       bb_c   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int k, cyc, last_done, seen, bad_upd;
    logic [7:0] prev;
    bus.start = 1'b0; bus.A = 8'h00; bus.opc = 2'b00; bus.amt = 3'd0;
    tick(); tick();
    chk("reset out", bus.out, 8'h00);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset done", bus.done, 1'b0);
`ifdef SHIFT_SEQ_CARRY_EN
    chk("reset carry", bus.carry, 1'b0);
`endif
    rst = 1'b0;
    tick();
    chk("idle busy", bus.busy, 1'b0);

    // Reset mid-SHIFT: FF SRL 7, three steps in.
    bus.start = 1'b1; bus.A = 8'hFF; bus.opc = 2'b11; bus.amt = 3'd7;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk("midop busy before rst", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst out", bus.out, 8'h00);
    chk("midrst busy", bus.busy, 1'b0);
    chk("midrst done", bus.done, 1'b0);
`ifdef SHIFT_SEQ_CARRY_EN
    chk("midrst carry", bus.carry, 1'b0);
`endif
    tick(); tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done || bus.busy || bus.out != 8'h00) seen++;
    end
    chk("no done after rst", seen, 0);

    run_op("rotr81", 8'h81, 2'b00, 3'd1, 8'hC0, 1'b1, 1'b0);
    run_op("sra80",  8'h80, 2'b10, 3'd3, 8'hF0, 1'b0, 1'b0);
    run_op("srl0f",  8'h0F, 2'b11, 3'd4, 8'h00, 1'b1, 1'b0);
    run_op("sla81",  8'h81, 2'b01, 3'd7, 8'h80, 1'b0, 1'b1);
    run_op("amt0",   8'h5A, 2'b10, 3'd0, 8'h5A, 1'b0, 1'b0);

    // start held high, operands switched in each DONE cycle.
    k = 0; cyc = 0; last_done = 0; bad_upd = 0;
    prev = bus.out;
    bus.start = 1'b1; bus.A = bb_a[0]; bus.opc = bb_op[0]; bus.amt = bb_amt[0];
    while (k < 4 && cyc < 100) begin
      tick();
      cyc++;
      if (!bus.done && bus.out !== prev) bad_upd++;
      prev = bus.out;
      if (bus.done) begin
        chk($sformatf("b2b%0d out", k), bus.out, bb_out[k]);
`ifdef SHIFT_SEQ_CARRY_EN
        chk($sformatf("b2b%0d carry", k), bus.carry, bb_c[k]);
`endif
        if (k > 0) chk($sformatf("b2b%0d gap", k), cyc - last_done, 1 + lat_of(bb_amt[k]));
        last_done = cyc;
        k++;
        if (k < 4) begin
          bus.A = bb_a[k]; bus.opc = bb_op[k]; bus.amt = bb_amt[k];
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    chk("b2b all done", k, 4);
    chk("b2b out only in done", bad_upd, 0);
    tick();
    chk("b2b end idle", bus.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
